act_stream_master: RTL

- Bus master that sits directly upstream of the activation slave and drives its sel/trans/write/addr/wdata bus.
- Takes one command: an activation type plus an element count. It writes the type register once, then loops per element: write input word, read result word.
- Input words arrive on a valid/ready stream. Results go out through an internal output FIFO on a valid/ready stream.

---
 rtl/act_stream_master.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/act_stream_master.sv
// Activation stream master: writes the type once, then per element writes the input word and reads the result into an output FIFO.
// Three cycles per element with a ready slave; reads stall while the FIFO is full, and inputs are taken only in WAIT_IN.

module act_stream_fifo #(
  parameter int DWidth = 32,
  parameter int Depth  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DWidth-1:0] push_dat_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DWidth-1:0] head_o
);
  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] CntFull = (AW+1)'(Depth);

  logic [DWidth-1:0] r_mem [Depth];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [AW:0]       r_cnt;
  logic              w_push;
  logic              w_pop;

  assign full_o  = (r_cnt == CntFull);
  assign empty_o = (r_cnt == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  // Head reads as zero while empty so the output is clean after reset.
  assign head_o  = empty_o ? '0 : r_mem[r_rd];

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= push_dat_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

module act_stream_master #(
  parameter int                DWidth    = 32,
  parameter logic [DWidth-1:0] BaseAddr  = '0,
  parameter int                FifoDepth = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DWidth-1:0] type_i,
  input  logic [15:0]       len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  input  logic              in_valid_i,
  input  logic [DWidth-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DWidth-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic              sel_o,
  output logic              trans_o,
  output logic              write_o,
  output logic              ready_o,
  output logic [DWidth-1:0] addr_o,
  output logic [DWidth-1:0] wdata_o,
  input  logic [DWidth-1:0] rdata_i,
  input  logic              resp_i,
  input  logic              ready_i
);
  localparam logic [DWidth-1:0] AddrType = BaseAddr;
  localparam logic [DWidth-1:0] AddrIn   = BaseAddr + DWidth'(4);
  localparam logic [DWidth-1:0] AddrOut  = BaseAddr + DWidth'(8);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_TYPE, S_WAIT_IN, S_WR_IN, S_RD_OUT, S_DONE, S_ERR
  } state_t;

  state_t            r_state;
  logic [15:0]       r_cnt;
  logic [15:0]       r_len;
  logic [DWidth-1:0] r_type;
  logic [DWidth-1:0] r_hold;
  logic              r_err;
  logic              r_zdone;

  logic              w_issue;
  logic              w_write;
  logic [DWidth-1:0] w_addr;
  logic [DWidth-1:0] w_wdata;
  logic              w_cmpl;
  logic              w_full;
  logic              w_empty;
  logic              w_push;

  // Bus decode depends only on registered state and the registered FIFO level.
  always_comb begin
    w_issue = 1'b0;
    w_write = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    unique case (r_state)
      S_WR_TYPE: begin w_issue = 1'b1; w_write = 1'b1; w_addr = AddrType; w_wdata = r_type; end
      S_WR_IN:   begin w_issue = 1'b1; w_write = 1'b1; w_addr = AddrIn;   w_wdata = r_hold; end
      S_RD_OUT:  begin w_issue = ~w_full; w_addr = AddrOut; end
      default: ;
    endcase
  end

  assign w_cmpl  = w_issue & ready_i;
  assign w_push  = w_cmpl & ~resp_i & (r_state == S_RD_OUT);

  assign sel_o      = w_issue;
  assign trans_o    = w_issue;
  assign ready_o    = w_issue;
  assign write_o    = w_write;
  assign addr_o     = w_addr;
  assign wdata_o    = w_wdata;
  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = (r_state == S_DONE) | r_zdone;
  assign err_o      = r_err;
  assign in_ready_o = (r_state == S_WAIT_IN);
  assign out_valid_o = ~w_empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_type  <= '0;
      r_hold  <= '0;
      r_err   <= 1'b0;
      r_zdone <= 1'b0;
    end else begin
      r_zdone <= 1'b0;
      if (w_cmpl && resp_i) begin
        r_state <= S_ERR;
        r_err   <= 1'b1;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (start_i) begin
              r_err <= 1'b0;
              if (len_i != '0) begin
                r_type  <= type_i;
                r_len   <= len_i;
                r_cnt   <= '0;
                r_state <= S_WR_TYPE;
              end else begin
                r_zdone <= 1'b1;
              end
            end
          end
          S_WR_TYPE: if (w_cmpl) r_state <= S_WAIT_IN;
          S_WAIT_IN: begin
            if (in_valid_i) begin
              r_hold  <= in_data_i;
              r_state <= S_WR_IN;
            end
          end
          S_WR_IN: if (w_cmpl) r_state <= S_RD_OUT;
          S_RD_OUT: begin
            if (w_cmpl) begin
              if (r_cnt == r_len - 16'd1) begin
                r_state <= S_DONE;
              end else begin
                r_cnt   <= r_cnt + 16'd1;
                r_state <= S_WAIT_IN;
              end
            end
          end
          S_DONE:  r_state <= S_IDLE;
          S_ERR:   r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  act_stream_fifo #(.DWidth(DWidth), .Depth(FifoDepth)) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (w_push),
    .push_dat_i (rdata_i),
    .pop_i      (out_valid_o & out_ready_i),
    .full_o     (w_full),
    .empty_o    (w_empty),
    .head_o     (out_data_o)
  );
endmodule
